// File: rtl/demux_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
package demux_pkg;
  localparam int N_CH  = 4;
  localparam int SEL_W = 2;
endpackage

// File: rtl/chan_fifo.sv
// Single-channel FIFO behind one demux output.
// State is EMPTY / PART / FULL, implied by the word count.
module chan_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  // A full channel refuses input even if it is popped in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // NOTE: storage is cleared on reset so the data output is a known 0
      // afterwards; this costs a reset path on every storage bit.
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (count != '0);
  assign full  = (count == CNT_W'(DEPTH));
endmodule

// File: rtl/demux1x4_stream.sv
// 1-to-4 valid/ready stream demultiplexer with a small FIFO per channel.
// Top level: select decode, in_ready mux and output concatenation only.
module demux1x4_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic [DATA_W-1:0]      in_data,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [N_CH-1:0]        ch_full
);
  logic [N_CH-1:0] push;
  logic [N_CH-1:0] full_vec;

  // Only the addressed channel's fullness gates the input; others never stall it.
  assign in_ready = ~full_vec[in_sel];
  assign ch_full  = full_vec;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign push[i] = in_valid & in_ready & (in_sel == SEL_W'(i));

    chan_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .din   (in_data),
      .pop   (out_ready[i]),
      .dout  (out_data[i*DATA_W +: DATA_W]),
      .valid (out_valid[i]),
      .full  (full_vec[i])
    );
  end
endmodule

// File: tb/tb_demux1x4_stream.sv
// Self-checking bench for demux1x4_stream: vector table, directed corner
// sequences and a random soak against a queue-based reference model.
module tb_demux1x4_stream;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [7:0]  in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic [3:0]  ch_full;

  demux1x4_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ch_full   (ch_full)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one bounded queue of words per channel.
  logic [7:0] model_q [4][$];

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [3:0]  rdy;
    logic        exp_ready;
    logic [3:0]  exp_valid;
    logic [3:0]  exp_full;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    #1;
  endtask

  // Advance one clock; the model applies the spec's accept/pop rules to the
  // inputs as they stand at the edge.
  task automatic clock_edge();
    bit acc;
    acc = in_valid && (model_q[in_sel].size() < DEPTH);
    for (int i = 0; i < 4; i++)
      if (out_ready[i] && model_q[i].size() > 0) void'(model_q[i].pop_front());
    if (rst_n && acc) model_q[in_sel].push_back(in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] ev, ef;
    for (int i = 0; i < 4; i++) begin
      ev[i] = model_q[i].size() > 0;
      ef[i] = model_q[i].size() == DEPTH;
    end
    check({tag, ".in_ready"}, 32'(in_ready), 32'(model_q[in_sel].size() < DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
    check({tag, ".ch_full"}, 32'(ch_full), 32'(ef));
    for (int i = 0; i < 4; i++)
      if (ev[i]) check($sformatf("%s.data%0d", tag, i), 32'(out_data[i*8 +: 8]), 32'(model_q[i][0]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) model_q[i].delete();
  endtask

  initial begin
    logic [31:0] mask;
    logic [7:0]  got [$];
    int          sent;
    int          cyc;

    // Basic route (rows 0-5), then full/backpressure and no-bypass (rows 6-13).
    // Expectations are the outputs seen with the row's inputs applied, before its edge.
    vecs[0]  = '{1'b1, 2'd0, 8'hA0, 4'hF, 1'b1, 4'b0000, 4'b0000, 32'h00000000};
    vecs[1]  = '{1'b1, 2'd1, 8'hA1, 4'hF, 1'b1, 4'b0001, 4'b0000, 32'h000000A0};
    vecs[2]  = '{1'b1, 2'd2, 8'hA2, 4'hF, 1'b1, 4'b0010, 4'b0000, 32'h0000A100};
    vecs[3]  = '{1'b1, 2'd3, 8'hA3, 4'hF, 1'b1, 4'b0100, 4'b0000, 32'h00A20000};
    vecs[4]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b1000, 4'b0000, 32'hA3000000};
    vecs[5]  = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 4'b0000, 32'h00000000};
    vecs[6]  = '{1'b1, 2'd2, 8'h11, 4'h0, 1'b1, 4'b0000, 4'b0000, 32'h00000000};
    vecs[7]  = '{1'b1, 2'd2, 8'h22, 4'h0, 1'b1, 4'b0100, 4'b0000, 32'h00110000};
    vecs[8]  = '{1'b1, 2'd2, 8'h44, 4'h0, 1'b0, 4'b0100, 4'b0100, 32'h00110000};
    vecs[9]  = '{1'b1, 2'd1, 8'h33, 4'h0, 1'b1, 4'b0100, 4'b0100, 32'h00110000};
    vecs[10] = '{1'b1, 2'd2, 8'h44, 4'h4, 1'b0, 4'b0110, 4'b0100, 32'h00113300};
    vecs[11] = '{1'b0, 2'd2, 8'h00, 4'h0, 1'b1, 4'b0110, 4'b0000, 32'h00223300};
    vecs[12] = '{1'b0, 2'd0, 8'h00, 4'hF, 1'b1, 4'b0110, 4'b0000, 32'h00223300};
    vecs[13] = '{1'b0, 2'd0, 8'h00, 4'h0, 1'b1, 4'b0000, 4'b0000, 32'h00000000};

    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    do_reset();

    check("reset.out_valid", 32'(out_valid), 32'h0);
    check("reset.out_data", out_data, 32'h0);
    check("reset.ch_full", 32'(ch_full), 32'h0);
    check("reset.in_ready", 32'(in_ready), 32'h1);

    for (int n = 0; n < 14; n++) begin
      drive(vecs[n].v, vecs[n].sel, vecs[n].data, vecs[n].rdy);
      for (int i = 0; i < 4; i++) mask[i*8 +: 8] = {8{vecs[n].exp_valid[i]}};
      check($sformatf("vec%0d.in_ready", n), 32'(in_ready), 32'(vecs[n].exp_ready));
      check($sformatf("vec%0d.out_valid", n), 32'(out_valid), 32'(vecs[n].exp_valid));
      check($sformatf("vec%0d.ch_full", n), 32'(ch_full), 32'(vecs[n].exp_full));
      check($sformatf("vec%0d.out_data", n), out_data & mask, vecs[n].exp_data & mask);
      clock_edge();
    end

    // Reset mid-stream: ch0 loaded with two words, input still asserted during reset.
    drive(1'b1, 2'd0, 8'h11, 4'h0);
    clock_edge();
    drive(1'b1, 2'd0, 8'h22, 4'h0);
    clock_edge();
    check("midrst.pre_valid", 32'(out_valid), 32'h1);
    drive(1'b1, 2'd0, 8'h99, 4'h0);
    do_reset();
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    check("midrst.out_valid", 32'(out_valid), 32'h0);
    check("midrst.out_data", out_data, 32'h0);
    check("midrst.in_ready", 32'(in_ready), 32'h1);
    check("midrst.ch_full", 32'(ch_full), 32'h0);

    // Simultaneous push and pop on a channel holding one word.
    drive(1'b1, 2'd0, 8'h77, 4'h0);
    clock_edge();
    drive(1'b1, 2'd0, 8'h55, 4'h1);
    check("pushpop.head_before", 32'(out_data[7:0]), 32'h77);
    check("pushpop.ready", 32'(in_ready), 32'h1);
    clock_edge();
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    check("pushpop.valid", 32'(out_valid), 32'h1);
    check("pushpop.head_after", 32'(out_data[7:0]), 32'h55);
    check("pushpop.not_full", 32'(ch_full), 32'h0);
    drive(1'b0, 2'd0, 8'h00, 4'h1);
    clock_edge();
    check("pushpop.one_word", 32'(out_valid), 32'h0);

    // Order and wrap on ch3: consumer ready every other cycle, producer back-to-back.
    sent = 0;
    cyc  = 0;
    got.delete();
    while ((sent < 16 || got.size() < 16) && cyc < 200) begin
      drive(sent < 16, 2'd3, 8'(sent), {cyc[0], 3'b000});
      check_model($sformatf("wrap%0d", cyc));
      if (out_valid[3] && out_ready[3]) got.push_back(out_data[31:24]);
      if (in_valid && in_ready) sent++;
      clock_edge();
      cyc++;
    end
    check("wrap.count", 32'(got.size()), 32'd16);
    for (int k = 0; k < got.size() && k < 16; k++)
      check($sformatf("wrap.word%0d", k), 32'(got[k]), 32'(k));

    // Random soak; the producer holds its word until it is accepted.
    drive(1'b0, 2'd0, 8'h00, 4'h0);
    for (int c = 0; c < 2000; c++) begin
      logic       v;
      logic [1:0] s;
      logic [7:0] d;
      if (in_valid && !in_ready) begin
        v = in_valid; s = in_sel; d = in_data;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom_range(0, 3));
        d = 8'($urandom);
      end
      drive(v, s, d, 4'($urandom));
      check_model($sformatf("soak%0d", c));
      if (ch_full[in_sel]) check($sformatf("soak%0d.ready_vs_full", c), 32'(in_ready), 32'h0);
      clock_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
